ps2_kbd_ctrl: RTL and testbench

//  Sequencer between ps2_keyboard's receive FIFO and the rest of the design. Drains the FIFO

---
 rtl/ps2_kbd_ctrl_if.sv | 23 ++
 rtl/ps2_kbd_ctrl.sv | 158 +++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_ctrl_if.sv
// Keyboard FIFO handshake plus key-event valid/ready port between ps2_kbd_ctrl and its neighbours.
// master = the controller; slave = FIFO source / event consumer side.
interface ps2_kbd_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (
    input  kbd_data, kbd_ready, kbd_overflow, ev_ready,
    output kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
  );

  modport slave (
    output kbd_data, kbd_ready, kbd_overflow, ev_ready,
    input  kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Drains the ps2_keyboard FIFO, folds E0/F0 prefixes into whole key events, tracks held key,
// counts new presses, and flags overflow / protocol errors.
module ps2_kbd_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_kbd_ctrl_if.master   bus,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] key_cnt,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             ovf_sticky,
  output logic             err
);

  typedef enum logic [1:0] {FETCH, DECODE, OUT} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state, state_nx;
  logic [7:0]       byte_r, byte_nx;
  logic             ext_r, ext_nx, brk_r, brk_nx;
  logic [TMO_W-1:0] tmr, tmr_nx;
  logic             pop_n, pop_n_nx;
  logic             ev_valid_r, ev_valid_nx;
  logic [7:0]       ev_code_r, ev_code_nx;
  logic             ev_ext_r, ev_ext_nx, ev_brk_r, ev_brk_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             held_valid_nx;
  logic [7:0]       held_code_nx;
  logic             ovf_nx, err_nx;

  assign bus.kbd_nextdata_n = pop_n;
  assign bus.ev_valid       = ev_valid_r;
  assign bus.ev_code        = ev_code_r;
  assign bus.ev_ext         = ev_ext_r;
  assign bus.ev_break       = ev_brk_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      byte_r     <= '0;
      ext_r      <= 1'b0;
      brk_r      <= 1'b0;
      tmr        <= '0;
      pop_n      <= 1'b1;
      ev_valid_r <= 1'b0;
      ev_code_r  <= '0;
      ev_ext_r   <= 1'b0;
      ev_brk_r   <= 1'b0;
      key_cnt    <= '0;
      held_valid <= 1'b0;
      held_code  <= '0;
      ovf_sticky <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_r     <= byte_nx;
      ext_r      <= ext_nx;
      brk_r      <= brk_nx;
      tmr        <= tmr_nx;
      pop_n      <= pop_n_nx;
      ev_valid_r <= ev_valid_nx;
      ev_code_r  <= ev_code_nx;
      ev_ext_r   <= ev_ext_nx;
      ev_brk_r   <= ev_brk_nx;
      key_cnt    <= cnt_nx;
      held_valid <= held_valid_nx;
      held_code  <= held_code_nx;
      ovf_sticky <= ovf_nx;
      err        <= err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    byte_nx       = byte_r;
    ext_nx        = ext_r;
    brk_nx        = brk_r;
    tmr_nx        = tmr;
    pop_n_nx      = 1'b1;
    ev_valid_nx   = ev_valid_r;
    ev_code_nx    = ev_code_r;
    ev_ext_nx     = ev_ext_r;
    ev_brk_nx     = ev_brk_r;
    cnt_nx        = key_cnt;
    held_valid_nx = held_valid;
    held_code_nx  = held_code;
    err_nx        = 1'b0;
    // overflow wins over a same-cycle clear so an event is never hidden
    ovf_nx        = bus.kbd_overflow ? 1'b1 : (clr_ovf ? 1'b0 : ovf_sticky);

    case (state)
      FETCH: begin
        if (bus.kbd_ready) begin
          byte_nx  = bus.kbd_data;
          pop_n_nx = 1'b0;
          tmr_nx   = '0;
          state_nx = DECODE;
        end else if (ext_r || brk_r) begin
          if (tmr == TMO_LAST) begin
            ext_nx = 1'b0;
            brk_nx = 1'b0;
            tmr_nx = '0;
            err_nx = 1'b1;
          end else begin
            tmr_nx = tmr + TMO_W'(1);
          end
        end else begin
          tmr_nx = '0;
        end
      end
      // kbd_ready is ignored here: the FIFO read pointer is still settling after the pop
      DECODE: begin
        state_nx = FETCH;
        case (byte_r)
          8'hE0: ext_nx = 1'b1;
          8'hF0: brk_nx = 1'b1;
          8'h00, 8'hFF: begin
            err_nx = 1'b1;
            ext_nx = 1'b0;
            brk_nx = 1'b0;
          end
          default: begin
            ev_valid_nx = 1'b1;
            ev_code_nx  = byte_r;
            ev_ext_nx   = ext_r;
            ev_brk_nx   = brk_r;
            state_nx    = OUT;
          end
        endcase
      end
      OUT: begin
        if (bus.ev_ready) begin
          ev_valid_nx = 1'b0;
          ext_nx      = 1'b0;
          brk_nx      = 1'b0;
          state_nx    = FETCH;
          if (!ev_brk_r) begin
            // typematic repeats of the held key are not new presses
            if (!(held_valid && held_code == ev_code_r)) begin
              cnt_nx        = key_cnt + CNT_W'(1);
              held_code_nx  = ev_code_r;
              held_valid_nx = 1'b1;
            end
          end else if (held_valid && held_code == ev_code_r) begin
            held_valid_nx = 1'b0;
          end
        end
      end
      default: state_nx = FETCH;
    endcase
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: byte-level FIFO model, event scoreboard, per-cycle checker.
module tb_ps2_kbd_ctrl;
  localparam int TMO_CYC = 16;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_ovf = 1'b0;
  logic [7:0] key_cnt;
  logic       held_valid;
  logic [7:0] held_code;
  logic       ovf_sticky;
  logic       err;

  ps2_kbd_ctrl_if bus();

  ps2_kbd_ctrl #(.CNT_W(8), .TMO_W(20), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_ovf(clr_ovf),
    .key_cnt(key_cnt), .held_valid(held_valid), .held_code(held_code),
    .ovf_sticky(ovf_sticky), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int pop_cnt = 0, err_cnt = 0, xfer_cnt = 0, exp_err = 0;
  bit started = 0;

  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  logic       m_ext = 0, m_brk = 0, m_hv = 0, m_ovf = 0;
  logic [7:0] m_cnt = 0, m_hc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_refresh();
    bus.kbd_ready = (fifo.size() != 0);
    bus.kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // Keyboard-side view of the byte stream: what events it must produce
  task automatic push_byte(input logic [7:0] b);
    ev_t e;
    fifo.push_back(b);
    fifo_refresh();
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) begin
      exp_err++; m_ext = 0; m_brk = 0;
    end else begin
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_timeout();
    m_ext = 0; m_brk = 0; exp_err++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (k < budget && !(fifo.size() == 0 && exp_q.size() == 0 && !bus.ev_valid)) begin
      tick(1); k++;
    end
    check(name, k < budget, 1);
    tick(4);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (k < budget && !bus.ev_valid) begin tick(1); k++; end
    check(name, k < budget, 1);
  endtask

  task automatic do_reset();
    rst = 1; tick(2); rst = 0; tick(1);
  endtask

  // FIFO pops on the cycle the strobe is low
  always @(posedge clk) begin
    #1;
    if (bus.kbd_nextdata_n === 1'b0 && fifo.size() > 0) void'(fifo.pop_front());
    fifo_refresh();
  end

  logic prev_hold = 0, prev_pop = 0, prev_err = 0;
  ev_t  prev_ev;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      m_cnt = 0; m_hv = 0; m_hc = 0; m_ovf = 0; m_ext = 0; m_brk = 0;
      exp_q.delete();
      prev_hold = 0; prev_pop = 0; prev_err = 0;
      started = 1;
    end else if (started) begin
      check("key_cnt", key_cnt, m_cnt);
      check("held_valid", held_valid, m_hv);
      if (m_hv) check("held_code", held_code, m_hc);
      check("ovf_sticky", ovf_sticky, m_ovf);
      if (bus.kbd_nextdata_n === 1'b0) begin
        pop_cnt++;
        check("pop_width", prev_pop, 0);
        check("pop_in_out", bus.ev_valid, 0);
      end
      prev_pop = (bus.kbd_nextdata_n === 1'b0);
      if (err === 1'b1) begin
        err_cnt++;
        check("err_width", prev_err, 0);
      end
      prev_err = (err === 1'b1);
      if (prev_hold) begin
        check("hold_valid", bus.ev_valid, 1);
        check("hold_fields", {bus.ev_code, bus.ev_ext, bus.ev_break}, prev_ev);
      end
      if (bus.ev_valid && bus.ev_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_event", {bus.ev_code, bus.ev_ext, bus.ev_break}, 0);
        else begin
          e = exp_q.pop_front();
          check("ev_fields", {bus.ev_code, bus.ev_ext, bus.ev_break}, e);
          if (!e.brk) begin
            if (!(m_hv && m_hc == e.code)) begin
              m_cnt = m_cnt + 8'd1; m_hc = e.code; m_hv = 1;
            end
          end else if (m_hv && m_hc == e.code) m_hv = 0;
        end
      end
      if (bus.kbd_overflow) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      prev_hold = bus.ev_valid && !bus.ev_ready;
      prev_ev   = {bus.ev_code, bus.ev_ext, bus.ev_break};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, e0, x0;
    bus.ev_ready = 1; bus.kbd_overflow = 0;
    fifo_refresh();
    tick(3); rst = 0; tick(1);
    check("rst_ev_valid", bus.ev_valid, 0);
    check("rst_nextdata_n", bus.kbd_nextdata_n, 1);
    check("rst_ev_code", {bus.ev_code, bus.ev_ext, bus.ev_break}, 0);
    check("rst_key_cnt", key_cnt, 0);
    check("rst_held", {held_valid, held_code}, 0);
    check("rst_ovf_err", {ovf_sticky, err}, 0);

    // 1: press and release of 1C
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    wait_idle("t1_idle", 200);
    check("t1_key_cnt", key_cnt, 1);
    check("t1_held_valid", held_valid, 0);

    // 2: extended press/release, 5 pops
    p0 = pop_cnt;
    push_byte(8'hE0); push_byte(8'h75); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    wait_idle("t2_idle", 200);
    check("t2_pops", pop_cnt - p0, 5);
    check("t2_key_cnt", key_cnt, 2);

    // 3: typematic, then wrap
    do_reset();
    x0 = xfer_cnt;
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    wait_idle("t3_idle", 200);
    check("t3_events", xfer_cnt - x0, 4);
    check("t3_key_cnt", key_cnt, 1);
    for (int i = 0; i < 260; i++) push_byte((i % 2) ? 8'h16 : 8'h15);
    wait_idle("t3_wrap_idle", 3000);
    check("t3_wrap_cnt", key_cnt, 5);
    check("t3_wrap_held", {held_valid, held_code}, {1'b1, 8'h16});

    // 4: backpressure
    bus.ev_ready = 0;
    push_byte(8'h1C);
    wait_valid("t4_valid", 50);
    push_byte(8'h2B);
    p0 = pop_cnt;
    tick(50);
    check("t4_no_pops", pop_cnt - p0, 0);
    check("t4_code", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h1C, 2'b00});
    bus.ev_ready = 1;
    tick(1);
    check("t4_xfer_1cyc", bus.ev_valid, 0);
    wait_idle("t4_idle", 200);
    check("t4_key_cnt", key_cnt, 7);
    check("t4_held", held_code, 8'h2B);

    // 5: prefix timeout
    do_reset();
    e0 = err_cnt;
    push_byte(8'hF0);
    tick(TMO_CYC + 14);
    check("t5_timeout_err", err_cnt - e0, 1);
    model_timeout();
    push_byte(8'h2B);
    wait_idle("t5_idle", 200);
    check("t5_press", {key_cnt, held_valid, held_code}, {8'd1, 1'b1, 8'h2B});

    // 6: FF discard, overflow, reset in OUT
    e0 = err_cnt; x0 = xfer_cnt;
    push_byte(8'hFF);
    wait_idle("t6_idle", 200);
    check("t6_ff_err", err_cnt - e0, 1);
    check("t6_no_event", xfer_cnt - x0, 0);
    bus.kbd_overflow = 1; tick(1); bus.kbd_overflow = 0; tick(5);
    check("t6_ovf_set", ovf_sticky, 1);
    clr_ovf = 1; tick(1); clr_ovf = 0; tick(1);
    check("t6_ovf_clr", ovf_sticky, 0);
    bus.kbd_overflow = 1; clr_ovf = 1; tick(1); bus.kbd_overflow = 0; clr_ovf = 0; tick(1);
    check("t6_ovf_set_wins", ovf_sticky, 1);
    bus.ev_ready = 0;
    push_byte(8'h3A);
    wait_valid("t6_valid", 50);
    rst = 1; tick(1); rst = 0;
    check("t6_rst_ev", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, 0);
    check("t6_rst_state", {key_cnt, held_valid, held_code, ovf_sticky, err}, 0);
    check("t6_rst_nextdata", bus.kbd_nextdata_n, 1);
    bus.ev_ready = 1;
    tick(5);

    check("err_total", err_cnt, exp_err);
    check("events_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
